// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-bus requests and builds the
// {valid, pc, instr} bundle for the IF/ID register. Handles stall, redirect and stale responses.
module fetch_stage #(
  parameter int unsigned    XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             ireq_valid,
  output logic [XLEN-1:0]  ireq_addr,
  input  logic             iresp_data_ok,
  input  logic [31:0]      iresp_data,
  output logic [XLEN+32:0] dataF_nxt
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]     ibuf_q, ibuf_d;
  logic [XLEN-1:0] redir_aligned;
  logic [XLEN-1:0] pc_inc;

  assign redir_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc        = pc_q + XLEN'(4);
  assign ireq_addr     = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    ibuf_d     = ibuf_q;
    ireq_valid = 1'b0;
    dataF_nxt  = '0;

    unique case (state_q)
      FETCH: begin
        ireq_valid = 1'b1;
        if (iresp_data_ok && !redirect_valid) begin
          // Same-cycle bypass so a zero-latency bus sustains one instruction per cycle.
          dataF_nxt = {1'b1, pc_q, iresp_data};
          if (stall) begin
            ibuf_d  = iresp_data;
            state_d = HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end else if (iresp_data_ok && redirect_valid) begin
          pc_d = redir_aligned;
        end else if (redirect_valid) begin
          // Request must stay stable until accepted; remember where to go afterwards.
          pend_pc_d = redir_aligned;
          state_d   = DISCARD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_aligned;
          state_d = FETCH;
        end else begin
          dataF_nxt = {1'b1, pc_q, ibuf_q};
          if (!stall) begin
            pc_d    = pc_inc;
            state_d = FETCH;
          end
        end
      end
      DISCARD: begin
        ireq_valid = 1'b1;
        if (redirect_valid) begin
          pend_pc_d = redir_aligned;
        end
        if (iresp_data_ok) begin
          pc_d    = redirect_valid ? redir_aligned : pend_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (reset) begin
      ireq_valid = 1'b0;
      dataF_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      pend_pc_q <= '0;
      ibuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      ibuf_q    <= ibuf_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations for streaming, stall/hold,
// redirect while a request is outstanding, wrap-around and reset mid-request.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic [96:0] dataF_nxt;

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage #(
    .XLEN    (64),
    .PC_RESET(64'h0000_0000_8000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dataF_nxt     (dataF_nxt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Apply this cycle's inputs shortly after the edge and let combinational outputs settle.
  task automatic drive(input logic dok, input logic [31:0] data, input logic st,
                       input logic rv, input logic [63:0] rpc);
    iresp_data_ok  = dok;
    iresp_data     = data;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    chk("rst_ireq_valid", 128'(ireq_valid), 128'(1'b0));
    chk("rst_dataF", 128'(dataF_nxt), 128'(97'h0));
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    do_reset();
    chk("post_rst_addr", 128'(ireq_addr), 128'(64'h8000_0000));

    // Back-to-back fetches with a same-cycle bus.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
      chk("stream_valid", 128'(ireq_valid), 128'(1'b1));
      chk("stream_addr", 128'(ireq_addr), 128'(64'h8000_0000 + 64'(4 * i)));
      chk("stream_dataF", 128'(dataF_nxt),
          128'({1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0013}));
      tick();
    end

    // Stall: response at 0x80000004 captured and held.
    do_reset();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    tick();
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'h0);
    chk("stall_first", 128'(dataF_nxt), 128'({1'b1, 64'h8000_0004, 32'hDEAD_BEEF}));
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      chk("hold_ireq_valid", 128'(ireq_valid), 128'(1'b0));
      chk("hold_dataF", 128'(dataF_nxt), 128'({1'b1, 64'h8000_0004, 32'hDEAD_BEEF}));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("hold_release_dataF", 128'(dataF_nxt), 128'({1'b1, 64'h8000_0004, 32'hDEAD_BEEF}));
    tick();
    chk("after_hold_addr", 128'(ireq_addr), 128'(64'h8000_0008));
    chk("after_hold_valid", 128'(ireq_valid), 128'(1'b1));

    // Advance to 0x80000010.
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    tick();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    tick();

    // Redirect while request outstanding.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_1000);
    chk("disc_enter_addr", 128'(ireq_addr), 128'(64'h8000_0010));
    chk("disc_enter_dataF", 128'(dataF_nxt), 128'(97'h0));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("disc_wait_valid", 128'(ireq_valid), 128'(1'b1));
    chk("disc_wait_addr", 128'(ireq_addr), 128'(64'h8000_0010));
    tick();
    drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 64'h0);
    chk("disc_drop_addr", 128'(ireq_addr), 128'(64'h8000_0010));
    chk("disc_drop_dataF", 128'(dataF_nxt), 128'(97'h0));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("redir_addr", 128'(ireq_addr), 128'(64'h8000_1000));
    chk("redir_valid", 128'(ireq_valid), 128'(1'b1));
    chk("idle_dataF", 128'(dataF_nxt), 128'(97'h0));
    tick();

    // Latest redirect wins in DISCARD.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_1000);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_2000);
    chk("disc2_addr", 128'(ireq_addr), 128'(64'h8000_1000));
    tick();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    chk("disc2_dataF", 128'(dataF_nxt), 128'(97'h0));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("latest_redir_addr", 128'(ireq_addr), 128'(64'h8000_2000));
    tick();

    // Redirect coincident with data_ok in DISCARD uses the new target.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_2100);
    tick();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b1, 64'h8000_2204);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("coinc_redir_addr", 128'(ireq_addr), 128'(64'h8000_2204));

    // Redirect during HOLD drops the buffered word and aligns the target.
    drive(1'b1, 32'h1111_1111, 1'b1, 1'b0, 64'h0);
    chk("hold2_first", 128'(dataF_nxt), 128'({1'b1, 64'h8000_2204, 32'h1111_1111}));
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 64'h8000_3002);
    chk("hold_redir_dataF", 128'(dataF_nxt), 128'(97'h0));
    chk("hold_redir_ireq", 128'(ireq_valid), 128'(1'b0));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("hold_redir_addr", 128'(ireq_addr), 128'(64'h8000_3000));
    chk("hold_redir_idle", 128'(dataF_nxt), 128'(97'h0));
    tick();
    drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 64'h0);
    chk("new_stream_dataF", 128'(dataF_nxt), 128'({1'b1, 64'h8000_3000, 32'h2222_2222}));
    tick();

    // PC wrap-around, then reset while a request is waiting.
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("redir_ok_dataF", 128'(dataF_nxt), 128'(97'h0));
    tick();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    chk("wrap_addr", 128'(ireq_addr), 128'(64'hFFFF_FFFF_FFFF_FFFC));
    chk("wrap_dataF", 128'(dataF_nxt), 128'({1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013}));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("wrapped_addr", 128'(ireq_addr), 128'(64'h0));
    chk("wait_valid", 128'(ireq_valid), 128'(1'b1));
    tick();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("mid_rst_ireq_valid", 128'(ireq_valid), 128'(1'b0));
    chk("mid_rst_dataF", 128'(dataF_nxt), 128'(97'h0));
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("post_mid_rst_addr", 128'(ireq_addr), 128'(64'h8000_0000));
    chk("post_mid_rst_valid", 128'(ireq_valid), 128'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
